bus_bridge: RTL and testbench

//  Address decoder / bridge directly downstream of the single-cycle CPU bus port.

---
 rtl/bus_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_bridge.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge.sv
// bus_bridge: address decoder between the single-cycle CPU bus and the data
// DRAM / on-board memory-mapped peripherals (7-seg, LEDs, switches, buttons).
// Accesses with Bus_addr[31:12] == 20'hFFFFF go to the peripheral block;
// everything else goes to DRAM. Loads return combinationally (old value on a
// same-cycle store), stores commit on the rising edge of cpu_clk.
// Optional feature macro: BRIDGE_TIMER_EN adds a free-running 32-bit timer at
// peripheral offset 0x020; without it that offset reads 0 and ignores writes.
module bus_bridge #(
   parameter int SCAN_DIV = 50000,
   parameter int DRAM_AW  = 16
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic               Bus_we,
   input  logic [31:0]        Bus_wdata,
   output logic [31:0]        Bus_rdata,
   output logic [DRAM_AW-1:0] dram_addr,
   output logic               dram_we,
   output logic [31:0]        dram_wdata,
   input  logic [31:0]        dram_rdata,
   input  logic [23:0]        sw,
   input  logic [4:0]         btn,
   output logic [23:0]        led,
   output logic [7:0]         dig_en,
   output logic [7:0]         dn_seg
);

   // Peripheral offsets within the 4 KiB peripheral page
   localparam logic [11:0] OFF_DIG = 12'h000;
   localparam logic [11:0] OFF_TMR = 12'h020;
   localparam logic [11:0] OFF_LED = 12'h060;
   localparam logic [11:0] OFF_SW  = 12'h070;
   localparam logic [11:0] OFF_BTN = 12'h078;

   localparam int              SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   // Active-low hex-to-7-segment decode, segment order {dp,g,f,e,d,c,b,a}, dp off
   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         4'hF:    seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
      return seg;
   endfunction

   // Decode and write strobes
   logic        periph_s;
   logic [11:0] off_s;
   logic        per_we_s;
   logic        dig_wr_s;
   logic        led_wr_s;

   // Registers
   logic [31:0]       dig_q,      dig_d;
   logic [23:0]       led_q,      led_d;
   logic [23:0]       sw_meta_q;
   logic [23:0]       sw_sync_q;
   logic [4:0]        btn_meta_q;
   logic [4:0]        btn_sync_q;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]        dig_idx_q,  dig_idx_d;
   logic [7:0]        dig_en_q,   dig_en_d;
   logic [7:0]        dn_seg_q,   dn_seg_d;
   logic [31:0]       per_rdata_s;

`ifdef BRIDGE_TIMER_EN
   logic        tmr_wr_s;
   logic [31:0] tmr_q, tmr_d;
`endif

   assign periph_s   = (Bus_addr[31:12] == 20'hFFFFF);
   assign off_s      = Bus_addr[11:0];
   assign per_we_s   = Bus_we & periph_s;
   assign dig_wr_s   = per_we_s & (off_s == OFF_DIG);
   assign led_wr_s   = per_we_s & (off_s == OFF_LED);

   // DRAM side: pass-through address/data, stores only when not a peripheral access
   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_we    = Bus_we & ~periph_s;
   assign dram_wdata = Bus_wdata;

   assign led        = led_q;
   assign dig_en     = dig_en_q;
   assign dn_seg     = dn_seg_q;

`ifdef BRIDGE_TIMER_EN
   assign tmr_wr_s   = per_we_s & (off_s == OFF_TMR);

   // Timer next state: a bus load takes priority over the free-running increment
   always_comb begin
      tmr_d = tmr_q + 32'd1;
      if (tmr_wr_s) begin
         tmr_d = Bus_wdata;
      end else begin
         tmr_d = tmr_q + 32'd1;
      end
   end

   // Timer register
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         tmr_q <= 32'd0;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`endif

   // Peripheral read mux; unmapped offsets return zero
   always_comb begin
      per_rdata_s = 32'd0;
      case (off_s)
         OFF_DIG: per_rdata_s = dig_q;
         OFF_LED: per_rdata_s = {8'h00, led_q};
         OFF_SW:  per_rdata_s = {8'h00, sw_sync_q};
         OFF_BTN: per_rdata_s = {27'd0, btn_sync_q};
`ifdef BRIDGE_TIMER_EN
         OFF_TMR: per_rdata_s = tmr_q;
`endif
         default: per_rdata_s = 32'd0;
      endcase
   end

   // Return path to the CPU: combinational, pre-edge register values
   always_comb begin
      Bus_rdata = dram_rdata;
      if (periph_s) begin
         Bus_rdata = per_rdata_s;
      end else begin
         Bus_rdata = dram_rdata;
      end
   end

   // Display/LED register next state
   always_comb begin
      dig_d = dig_q;
      led_d = led_q;
      if (dig_wr_s) begin
         dig_d = Bus_wdata;
      end else begin
         dig_d = dig_q;
      end
      if (led_wr_s) begin
         led_d = Bus_wdata[23:0];
      end else begin
         led_d = led_q;
      end
   end

   // Scanner next state: free-running digit dwell counter and digit index;
   // the digit outputs are computed from next-state values so the registered
   // outputs show a DIG write in the cycle right after its edge
   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      dig_idx_d  = dig_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_idx_d  = dig_idx_q + 3'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
         dig_idx_d  = dig_idx_q;
      end
      dig_en_d = ~(8'b0000_0001 << dig_idx_d);
      dn_seg_d = hex_to_seg(dig_d[{dig_idx_d, 2'b00} +: 4]);
   end

   // Bus-writable peripheral registers
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         dig_q <= 32'd0;
         led_q <= 24'd0;
      end else begin
         dig_q <= dig_d;
         led_q <= led_d;
      end
   end

   // Two-flop synchronizers for the asynchronous switches and buttons
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         sw_meta_q  <= 24'd0;
         sw_sync_q  <= 24'd0;
         btn_meta_q <= 5'd0;
         btn_sync_q <= 5'd0;
      end else begin
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Display scanner state and registered digit/segment drive
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= 3'd0;
         dig_en_q   <= 8'hFE;
         dn_seg_q   <= 8'hC0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         dig_idx_q  <= dig_idx_d;
         dig_en_q   <= dig_en_d;
         dn_seg_q   <= dn_seg_d;
      end
   end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed testbench for bus_bridge (SCAN_DIV = 4) with a small DRAM model.
module tb_bus_bridge;

   logic        cpu_clk;
   logic        cpu_rst;
   logic [31:0] Bus_addr;
   logic        Bus_we;
   logic [31:0] Bus_wdata;
   logic [31:0] Bus_rdata;
   logic [15:0] dram_addr;
   logic        dram_we;
   logic [31:0] dram_wdata;
   logic [31:0] dram_rdata;
   logic [23:0] sw;
   logic [4:0]  btn;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [7:0]  dn_seg;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   bus_bridge #(.SCAN_DIV(4), .DRAM_AW(16)) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .Bus_addr   (Bus_addr),
      .Bus_we     (Bus_we),
      .Bus_wdata  (Bus_wdata),
      .Bus_rdata  (Bus_rdata),
      .dram_addr  (dram_addr),
      .dram_we    (dram_we),
      .dram_wdata (dram_wdata),
      .dram_rdata (dram_rdata),
      .sw         (sw),
      .btn        (btn),
      .led        (led),
      .dig_en     (dig_en),
      .dn_seg     (dn_seg)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // DRAM model: synchronous write, asynchronous read
   always @(posedge cpu_clk) begin
      if (dram_we) mem[dram_addr[7:0]] <= dram_wdata;
   end
   assign dram_rdata = mem[dram_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance past one rising edge, then settle
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge cpu_clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      cpu_rst   = 1'b1;
      Bus_addr  = 32'd0;
      Bus_we    = 1'b0;
      Bus_wdata = 32'd0;
      sw        = 24'd0;
      btn       = 5'd0;
      step(2);
      chk("reset_led",    {8'd0, led},    32'h0);
      chk("reset_dig_en", {24'd0, dig_en}, 32'hFE);
      chk("reset_dn_seg", {24'd0, dn_seg}, 32'hC0);
      cpu_rst = 1'b0;

      // T1: DRAM store then load
      Bus_addr = 32'h0000_0100; Bus_we = 1'b1; Bus_wdata = 32'h1234_5678; #1;
      chk("t1_dram_we",    {31'd0, dram_we},   32'h1);
      chk("t1_dram_addr",  {16'd0, dram_addr}, 32'h40);
      chk("t1_dram_wdata", dram_wdata,         32'h1234_5678);
      step(1);
      Bus_we = 1'b0; #1;
      chk("t1_load", Bus_rdata, 32'h1234_5678);

      // T2: LED store, old value during store, new value after
      Bus_addr = 32'hFFFF_F060; Bus_we = 1'b1; Bus_wdata = 32'h00AB_CDEF; #1;
      chk("t2_dram_we", {31'd0, dram_we}, 32'h0);
      chk("t2_old_rd",  Bus_rdata,        32'h0);
      step(1);
      Bus_we = 1'b0; #1;
      chk("t2_led",  {8'd0, led}, 32'h00AB_CDEF);
      chk("t2_read", Bus_rdata,   32'h00AB_CDEF);

      // Unmapped peripheral write: ignored, reads zero, aliasing DRAM word untouched
      Bus_addr = 32'hFFFF_F100; Bus_we = 1'b1; Bus_wdata = 32'hDEAD_BEEF; #1;
      chk("unmap_rd", Bus_rdata, 32'h0);
      step(1);
      Bus_we = 1'b0;
      Bus_addr = 32'hFFFF_F060; #1;
      chk("unmap_led", Bus_rdata, 32'h00AB_CDEF);
      Bus_addr = 32'hFFFF_F000; #1;
      chk("unmap_dig", Bus_rdata, 32'h0);
      Bus_addr = 32'h0000_0100; #1;
      chk("unmap_dram", Bus_rdata, 32'h1234_5678);

      // T3: switch/button synchronizer latency
      sw = 24'h00F00F; btn = 5'h15;
      Bus_addr = 32'hFFFF_F070; #1;
      chk("t3_sw_e0", Bus_rdata, 32'h0);
      step(1);
      chk("t3_sw_e1", Bus_rdata, 32'h0);
      step(1);
      chk("t3_sw_e2", Bus_rdata, 32'h0000_F00F);
      Bus_addr = 32'hFFFF_F078; #1;
      chk("t3_btn", Bus_rdata, 32'h15);

      // T4: scanner with SCAN_DIV=4, DIG=0xA5, scan restarted by reset
      cpu_rst = 1'b1;
      step(1);
      cpu_rst = 1'b0;
      Bus_addr = 32'hFFFF_F000; Bus_we = 1'b1; Bus_wdata = 32'h0000_00A5;
      step(1);                                  // edge 1
      Bus_we = 1'b0; #1;
      chk("t4_d0_en",  {24'd0, dig_en}, 32'hFE);
      chk("t4_d0_seg", {24'd0, dn_seg}, 32'h92);
      chk("t4_dig_rd", Bus_rdata,       32'hA5);
      step(3);                                  // edge 4
      chk("t4_d1_en",  {24'd0, dig_en}, 32'hFD);
      chk("t4_d1_seg", {24'd0, dn_seg}, 32'h88);
      step(27);                                 // edge 31
      chk("t4_d7_en",  {24'd0, dig_en}, 32'h7F);
      chk("t4_d7_seg", {24'd0, dn_seg}, 32'hC0);
      step(1);                                  // edge 32
      chk("t4_wrap_en",  {24'd0, dig_en}, 32'hFE);
      chk("t4_wrap_seg", {24'd0, dn_seg}, 32'h92);

      // T5: reset wins over a coincident LED write
      Bus_addr = 32'hFFFF_F060; Bus_we = 1'b1; Bus_wdata = 32'h0012_3456;
      step(1);
      chk("t5_pre_led", {8'd0, led}, 32'h0012_3456);
      Bus_wdata = 32'h00FF_FFFF; cpu_rst = 1'b1;
      step(1);
      cpu_rst = 1'b0; Bus_we = 1'b0; #1;
      chk("t5_led",    {8'd0, led},     32'h0);
      chk("t5_dig_en", {24'd0, dig_en}, 32'hFE);
      chk("t5_dn_seg", {24'd0, dn_seg}, 32'hC0);
      Bus_addr = 32'hFFFF_F000; #1;
      chk("t5_dig", Bus_rdata, 32'h0);

`ifdef BRIDGE_TIMER_EN
      // T6: timer load and wrap
      Bus_addr = 32'hFFFF_F020; Bus_we = 1'b1; Bus_wdata = 32'hFFFF_FFFE;
      step(1);
      Bus_we = 1'b0; #1;
      chk("t6_c1", Bus_rdata, 32'hFFFF_FFFE);
      step(1);
      chk("t6_c2", Bus_rdata, 32'hFFFF_FFFF);
      step(1);
      chk("t6_c3", Bus_rdata, 32'h0000_0000);
`else
      // Timer absent: 0x020 behaves as unmapped
      Bus_addr = 32'hFFFF_F020; Bus_we = 1'b1; Bus_wdata = 32'h5555_AAAA;
      step(1);
      Bus_we = 1'b0; #1;
      chk("tmr_off_rd", Bus_rdata, 32'h0);
      step(2);
      chk("tmr_off_rd2", Bus_rdata, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
